// File: rtl/res_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : res_bcd_conv
// Brief    : Sequential double-dabble converter. Turns a 16-bit ALU result
//            into 5 packed BCD digits with valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
module res_bcd_conv #(
    parameter int W_IN  = 16,
    parameter int N_DIG = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_IN-1:0]      res_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*N_DIG-1:0]   bcd,
    output logic [2:0]           ndig,
    output logic                 busy
);

    localparam int c_bcd_w = 4 * N_DIG;
    localparam int c_sr_w  = c_bcd_w + W_IN;
    localparam int c_cnt_w = $clog2(W_IN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W_IN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_sr_w-1:0]   shreg_q, shreg_d;
    logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
    logic [c_bcd_w-1:0]  bcd_q,   bcd_d;

    logic [c_sr_w-1:0]   w_corr;
    logic [c_sr_w-1:0]   w_shift;

    // Add-3 on every digit field before the shift; each field stays 4 bits
    // wide so no carry can ripple into the neighbouring digit.
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
            localparam int c_lo = W_IN + 4 * gi;
            assign w_corr[c_lo +: 4] = (shreg_q[c_lo +: 4] >= 4'd5)
                                     ? shreg_q[c_lo +: 4] + 4'd3
                                     : shreg_q[c_lo +: 4];
        end
    endgenerate

    assign w_corr[W_IN-1:0] = shreg_q[W_IN-1:0];
    assign w_shift          = w_corr << 1;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = {{c_bcd_w{1'b0}}, res_in};
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                shreg_d = w_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_cnt_last) begin
                    bcd_d   = w_shift[c_sr_w-1 -: c_bcd_w];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // Digit count for leading-zero blanking; a zero value still shows one digit.
    always_comb begin
        ndig = 3'd1;
        for (int i = 1; i < N_DIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ndig = 3'(i + 1);
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_CONV);
    assign bcd       = bcd_q;

endmodule
`default_nettype wire
